// File: rtl/alu_pkg.sv
// Shared definitions for the sequential 64-bit add/subtract unit.
// Contents:
//   - EXE_* : command codes that select the 32-bit ALU operation
//   - op_t : 64-bit operation select (add or subtract)
//   - state_t : sequencer states (IDLE, LO, HI, DONE)
//   - carry_out() : carry (add) or borrow (sub) out of one bit position,
//     rebuilt from the operand bits and the result bit
package alu_pkg;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;

  typedef enum logic {
    OP_ADD64 = 1'b0,
    OP_SUB64 = 1'b1
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // The ALU does not export its flags, so the carry or borrow out of a bit
  // position is rebuilt from that position's two operand bits and the
  // result bit the ALU produced there.
  function automatic logic carry_out(input logic is_sub, input logic a_bit,
                                     input logic b_bit, input logic r_bit);
    if (is_sub)
      return (~a_bit & b_bit) | ((~a_bit | b_bit) & r_bit);
    else
      return (a_bit & b_bit) | ((a_bit | b_bit) & ~r_bit);
  endfunction

endpackage

// File: rtl/seq64_flags.sv
// Combinational carry/borrow and 64-bit flag generation.
// Ports:
//   op      : add or subtract currently in flight
//   a_lo31  : bit 31 of operand a (low-word MSB)
//   b_lo31  : bit 31 of operand b (low-word MSB)
//   r_lo31  : bit 31 of the ALU result while the low word is driven
//   a63     : bit 63 of operand a
//   b63     : bit 63 of operand b
//   sum     : assembled 64-bit result (high word from the ALU, low word
//             from the register)
//   low_cb  : carry (add) or borrow (sub) out of bit 31
//   n, z, c, v : 64-bit flags, ARM convention (c is NOT borrow for sub)
module seq64_flags
  import alu_pkg::*;
(
  input  op_t         op,
  input  logic        a_lo31,
  input  logic        b_lo31,
  input  logic        r_lo31,
  input  logic        a63,
  input  logic        b63,
  input  logic [63:0] sum,
  output logic        low_cb,
  output logic        n,
  output logic        z,
  output logic        c,
  output logic        v
);

  logic is_sub;
  logic hi_cb;

  // Carry/borrow out of both word boundaries, then the ARM-style flags on
  // the full 64-bit result. For subtraction the C flag is the inverse of
  // the borrow, and overflow is only possible when the operand signs differ.
  always_comb begin
    is_sub = (op == OP_SUB64);
    low_cb = carry_out(is_sub, a_lo31, b_lo31, r_lo31);
    hi_cb  = carry_out(is_sub, a63, b63, sum[63]);
    n      = sum[63];
    z      = (sum == 64'd0);
    c      = is_sub ? ~hi_cb : hi_cb;
    if (is_sub)
      v = (a63 != b63) && (sum[63] != a63);
    else
      v = (a63 == b63) && (sum[63] != a63);
  end

endmodule

// File: rtl/alu_seq64.sv
// Sequential 64-bit add/subtract built on an external 32-bit ALU. The low
// word is computed in LO and the high word in HI. The carry or borrow is
// chained between the two words through alu_c_in.
// Ports:
//   clk, rst            : clock; synchronous active-low reset
//   start, op, a, b     : request, operation (0 add, 1 sub), 64-bit operands
//   abort               : cancel an operation in LO or HI
//   alu_val1, alu_val2  : ALU operand drive
//   alu_c_in            : ALU carry-in drive
//   alu_exe_cmd         : ALU command drive
//   alu_result          : ALU combinational result
//   busy, done          : in-flight indicator; one-cycle completion pulse
//   result, n, z, c, v  : 64-bit result and flags, held between operations
module alu_seq64
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic        abort,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [31:0] alu_val1,
  output logic [31:0] alu_val2,
  output logic        alu_c_in,
  output logic [3:0]  alu_exe_cmd,
  input  logic [31:0] alu_result,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic        n,
  output logic        z,
  output logic        c,
  output logic        v
);

  state_t      state;
  state_t      state_next;
  logic [63:0] a_q;
  logic [63:0] b_q;
  op_t         op_q;
  logic [31:0] res_lo_q;
  logic        low_cb_q;
  logic        accept;
  logic        f_low_cb;
  logic        f_n;
  logic        f_z;
  logic        f_c;
  logic        f_v;

  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

  seq64_flags u_flags (
    .op     (op_q),
    .a_lo31 (a_q[31]),
    .b_lo31 (b_q[31]),
    .r_lo31 (alu_result[31]),
    .a63    (a_q[63]),
    .b63    (b_q[63]),
    .sum    ({alu_result, res_lo_q}),
    .low_cb (f_low_cb),
    .n      (f_n),
    .z      (f_z),
    .c      (f_c),
    .v      (f_v)
  );

  // State register. Reset overrides both abort and start.
  always_ff @(posedge clk) begin
    if (!rst)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // Next-state logic. Start is only looked at in IDLE and DONE, so a
  // request during LO/HI is dropped rather than queued. Abort only matters
  // in LO/HI.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: state_next = start ? ST_LO : ST_IDLE;
      ST_LO:   state_next = abort ? ST_IDLE : ST_HI;
      ST_HI:   state_next = abort ? ST_IDLE : ST_DONE;
      ST_DONE: state_next = start ? ST_LO : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode. LO drives the low words with no carry-in. HI drives the
  // high words and chains the low carry in. For subtraction the carry-in
  // is the inverted borrow. All other states park the ALU on NOP with
  // zero operands.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    alu_val1    = 32'd0;
    alu_val2    = 32'd0;
    alu_c_in    = 1'b0;
    alu_exe_cmd = EXE_NOP;
    case (state)
      ST_LO: begin
        busy        = 1'b1;
        alu_val1    = a_q[31:0];
        alu_val2    = b_q[31:0];
        alu_exe_cmd = (op_q == OP_SUB64) ? EXE_SUB : EXE_ADD;
      end
      ST_HI: begin
        busy        = 1'b1;
        alu_val1    = a_q[63:32];
        alu_val2    = b_q[63:32];
        alu_c_in    = (op_q == OP_SUB64) ? ~low_cb_q : low_cb_q;
        alu_exe_cmd = (op_q == OP_SUB64) ? EXE_SBC : EXE_ADC;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers. The low word goes into a private staging register
  // so the visible result only changes at the HI capture. This keeps the
  // previous answer intact through the next operation and through an
  // abort in LO or HI.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q      <= 64'd0;
      b_q      <= 64'd0;
      op_q     <= OP_ADD64;
      res_lo_q <= 32'd0;
      low_cb_q <= 1'b0;
      result   <= 64'd0;
      n        <= 1'b0;
      z        <= 1'b0;
      c        <= 1'b0;
      v        <= 1'b0;
    end else begin
      if (accept) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op_t'(op);
      end
      if ((state == ST_LO) && !abort) begin
        res_lo_q <= alu_result;
        low_cb_q <= f_low_cb;
      end
      if ((state == ST_HI) && !abort) begin
        result <= {alu_result, res_lo_q};
        n      <= f_n;
        z      <= f_z;
        c      <= f_c;
        v      <= f_v;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq64.sv
// Testbench for alu_seq64. A behavioural 32-bit ALU is connected to the
// alu_* ports. Directed vectors with hand-computed answers are issued.
// Each accepted request pushes its expected result and flags onto a
// scoreboard queue. A monitor pops and compares entries whenever done
// pulses.
module tb_alu_seq64;
  import alu_pkg::*;

  typedef struct packed {
    logic        op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic [3:0]  nzcv;
    logic [3:0]  hi_cmd;
    logic        hi_cin;
  } vec_t;

  typedef struct packed {
    logic [63:0] res;
    logic [3:0]  nzcv;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        op;
  logic        abort;
  logic [63:0] a;
  logic [63:0] b;
  logic [31:0] alu_val1;
  logic [31:0] alu_val2;
  logic        alu_c_in;
  logic [3:0]  alu_exe_cmd;
  logic [31:0] alu_result;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        n;
  logic        z;
  logic        c;
  logic        v;

  int   checks;
  int   errors;
  int   done_count;
  exp_t sb_q[$];
  vec_t vecs[7];
  vec_t b2b[3];

  alu_seq64 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .abort       (abort),
    .a           (a),
    .b           (b),
    .alu_val1    (alu_val1),
    .alu_val2    (alu_val2),
    .alu_c_in    (alu_c_in),
    .alu_exe_cmd (alu_exe_cmd),
    .alu_result  (alu_result),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .n           (n),
    .z           (z),
    .c           (c),
    .v           (v)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 32-bit ALU. SBC follows the ARM rule: a + ~b + carry.
  always_comb begin
    case (alu_exe_cmd)
      EXE_ADD: alu_result = alu_val1 + alu_val2;
      EXE_ADC: alu_result = alu_val1 + alu_val2 + 32'(alu_c_in);
      EXE_SUB: alu_result = alu_val1 - alu_val2;
      EXE_SBC: alu_result = alu_val1 + ~alu_val2 + 32'(alu_c_in);
      default: alu_result = 32'd0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and walk it through LO, HI and DONE. The HI drive
  // and the latency are checked along the way. The result and flags are
  // checked by the monitor through the scoreboard.
  task automatic applyStimulus(input vec_t t, input string name);
    op    = t.op;
    a     = t.a;
    b     = t.b;
    start = 1'b1;
    sb_q.push_back('{res: t.res, nzcv: t.nzcv});
    tick();
    start = 1'b0;
    tick();
    checkOutput({name, "_hi_cmd"}, 64'(alu_exe_cmd), 64'(t.hi_cmd));
    checkOutput({name, "_hi_cin"}, 64'(alu_c_in), 64'(t.hi_cin));
    tick();
    checkOutput({name, "_done_cycle3"}, 64'(done), 64'd1);
    tick();
    checkOutput({name, "_done_one_cycle"}, 64'(done), 64'd0);
  endtask

  // Scoreboard monitor. It samples on the falling edge, away from the
  // active edge, and pairs every done pulse with the oldest expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      exp_t e;
      done_count++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1 expected done=0 (result 0x%0h)", result);
      end else begin
        e = sb_q.pop_front();
        checkOutput("sb_result", result, e.res);
        checkOutput("sb_nzcv", 64'({n, z, c, v}), 64'(e.nzcv));
      end
    end
  end

  initial begin
    int base;
    checks     = 0;
    errors     = 0;
    done_count = 0;

    //                 op    a                      b                      result                 nzcv     hi_cmd   cin
    vecs[0] = '{1'b0, 64'h00000000_FFFFFFFF, 64'h1,                 64'h00000001_00000000, 4'b0000, EXE_ADC, 1'b1};
    vecs[1] = '{1'b1, 64'h00000001_00000000, 64'h1,                 64'h00000000_FFFFFFFF, 4'b0010, EXE_SBC, 1'b0};
    vecs[2] = '{1'b0, 64'h7FFFFFFF_FFFFFFFF, 64'h1,                 64'h80000000_00000000, 4'b1001, EXE_ADC, 1'b1};
    vecs[3] = '{1'b1, 64'h5,                 64'h5,                 64'h0,                 4'b0110, EXE_SBC, 1'b1};
    vecs[4] = '{1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'h1,                 64'h0,                 4'b0110, EXE_ADC, 1'b1};
    vecs[5] = '{1'b1, 64'h0,                 64'h1,                 64'hFFFFFFFF_FFFFFFFF, 4'b1000, EXE_SBC, 1'b0};
    vecs[6] = '{1'b1, 64'h80000000_00000000, 64'h1,                 64'h7FFFFFFF_FFFFFFFF, 4'b0011, EXE_SBC, 1'b0};

    b2b[0]  = '{1'b0, 64'h1,                 64'h2,                 64'h3,                 4'b0000, EXE_ADC, 1'b0};
    b2b[1]  = '{1'b1, 64'hA,                 64'h3,                 64'h7,                 4'b0010, EXE_SBC, 1'b1};
    b2b[2]  = '{1'b0, 64'h00000001_80000000, 64'h00000000_80000000, 64'h00000002_00000000, 4'b0000, EXE_ADC, 1'b1};

    rst   = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    abort = 1'b0;
    a     = 64'd0;
    b     = 64'd0;
    tick();
    tick();
    $display("[TB] checking reset state");
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_result", result, 64'd0);
    checkOutput("rst_nzcv", 64'({n, z, c, v}), 64'd0);
    checkOutput("rst_alu_cmd", 64'(alu_exe_cmd), 64'(EXE_NOP));
    checkOutput("rst_alu_vals", {alu_val1, alu_val2}, 64'd0);
    checkOutput("rst_alu_cin", 64'(alu_c_in), 64'd0);
    rst = 1'b1;
    tick();

    $display("[TB] directed vectors");
    for (int i = 0; i < 7; i++)
      applyStimulus(vecs[i], $sformatf("vec%0d", i));

    $display("[TB] back-to-back with start held high");
    base = done_count;
    for (int cyc = 0; cyc < 9; cyc++) begin
      if (cyc % 3 == 0) begin
        op = b2b[cyc / 3].op;
        a  = b2b[cyc / 3].a;
        b  = b2b[cyc / 3].b;
        sb_q.push_back('{res: b2b[cyc / 3].res, nzcv: b2b[cyc / 3].nzcv});
      end else begin
        op = 1'b1;
        a  = 64'hDEAD_BEEF_0000_1111 + 64'(cyc);
        b  = 64'h0123_4567_89AB_CDEF;
      end
      start = 1'b1;
      tick();
    end
    start = 1'b0;
    tick();
    tick();
    checkOutput("b2b_done_pulses", 64'(done_count - base), 64'd3);

    $display("[TB] abort in HI");
    op    = 1'b0;
    a     = 64'h5;
    b     = 64'h5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checkOutput("abort_busy_in_hi", 64'(busy), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_idle_cmd", 64'(alu_exe_cmd), 64'(EXE_NOP));
    checkOutput("abort_result_kept", result, 64'h00000002_00000000);
    checkOutput("abort_nzcv_kept", 64'({n, z, c, v}), 64'd0);
    tick();
    tick();
    tick();

    $display("[TB] reset in LO");
    op    = 1'b1;
    a     = 64'h9;
    b     = 64'h4;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("rstlo_busy_before", 64'(busy), 64'd1);
    rst   = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("rstlo_busy", 64'(busy), 64'd0);
    checkOutput("rstlo_done", 64'(done), 64'd0);
    checkOutput("rstlo_result", result, 64'd0);
    checkOutput("rstlo_nzcv", 64'({n, z, c, v}), 64'd0);
    checkOutput("rstlo_alu_cmd", 64'(alu_exe_cmd), 64'(EXE_NOP));
    checkOutput("rstlo_alu_vals", {alu_val1, alu_val2}, 64'd0);
    rst = 1'b1;
    tick();
    tick();
    tick();
    tick();

    checkOutput("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
